// File: rtl/oled_pixel_streamer_if.sv
// Renderer-facing pixel bus plus the Pmod OLED serial pins.
// The streamer is the master; the renderer/pin side is the slave.
interface oled_pixel_streamer_if;
  logic        enable;
  logic [15:0] oled_data;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        frame_begin;
  logic        sample_pixel;
  logic        busy;
  logic        cs_n;
  logic        sclk;
  logic        sdin;
  logic        dc;

  modport master (
    input  enable,
    input  oled_data,
    output x,
    output y,
    output frame_begin,
    output sample_pixel,
    output busy,
    output cs_n,
    output sclk,
    output sdin,
    output dc
  );

  modport slave (
    output enable,
    output oled_data,
    input  x,
    input  y,
    input  frame_begin,
    input  sample_pixel,
    input  busy,
    input  cs_n,
    input  sclk,
    input  sdin,
    input  dc
  );
endinterface

// File: rtl/oled_pixel_streamer.sv
// Raster-scans the panel, latches one RGB565 pixel per position from the renderer
// and shifts it MSB-first to the OLED controller over cs_n/sclk/sdin/dc.
module oled_pixel_streamer #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  oled_pixel_streamer_if.master  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [6:0]       x_q;
  logic [5:0]       y_q;
  logic             frame_begin_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             sdin_q;
  logic             dc_q;
  logic [15:0]      shift_q;
  logic [3:0]       bit_q;
  logic [DIV_W-1:0] div_q;
  logic [GAP_W-1:0] gap_q;

  logic div_done;
  logic gap_done;
  logic x_last;
  logic y_last;

  assign div_done = (div_q == DIV_LAST);
  assign gap_done = (gap_q == GAP_LAST);
  assign x_last   = (x_q == X_LAST);
  assign y_last   = (y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      frame_begin_q <= 1'b0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      sdin_q        <= 1'b0;
      dc_q          <= 1'b0;
      shift_q       <= '0;
      bit_q         <= '0;
      div_q         <= '0;
      gap_q         <= '0;
    end else begin
      frame_begin_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_q       <= S_LOAD;
            frame_begin_q <= 1'b1;
            cs_n_q        <= 1'b0;
            dc_q          <= 1'b1;
          end
        end

        // The shift register keeps only the bits still to be sent, so bit 15
        // of it is always the next bit to present on sdin.
        S_LOAD: begin
          state_q <= S_SHIFT;
          shift_q <= {bus.oled_data[14:0], 1'b0};
          sdin_q  <= bus.oled_data[15];
          sclk_q  <= 1'b0;
          bit_q   <= 4'd15;
          div_q   <= '0;
        end

        S_SHIFT: begin
          if (!div_done) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q != 4'd0) begin
              sclk_q  <= 1'b0;
              sdin_q  <= shift_q[15];
              shift_q <= {shift_q[14:0], 1'b0};
              bit_q   <= bit_q - 4'd1;
            end else if (!x_last) begin
              // sclk stays high through LOAD; the next falling edge starts the next pixel.
              x_q     <= x_q + 7'd1;
              state_q <= S_LOAD;
            end else if (!y_last) begin
              x_q     <= '0;
              y_q     <= y_q + 6'd1;
              state_q <= S_LOAD;
            end else begin
              x_q     <= '0;
              y_q     <= '0;
              gap_q   <= '0;
              cs_n_q  <= 1'b1;
              dc_q    <= 1'b0;
              sdin_q  <= 1'b0;
              state_q <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (!gap_done) begin
            gap_q <= gap_q + GAP_W'(1);
          end else begin
            gap_q <= '0;
            if (bus.enable) begin
              state_q       <= S_LOAD;
              frame_begin_q <= 1'b1;
              cs_n_q        <= 1'b0;
              dc_q          <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.frame_begin  = frame_begin_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.sclk         = sclk_q;
  assign bus.sdin         = sdin_q;
  assign bus.dc           = dc_q;
  assign bus.sample_pixel = (state_q == S_LOAD);
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 24x12 panel so that
// several full frames fit in a short run.
module tb_oled_pixel_streamer;

  localparam int W     = 24;
  localparam int H     = 12;
  localparam int CD    = 2;
  localparam int GAP   = 16;
  localparam int PIX   = 1 + 32 * CD;
  localparam int FRAME = W * H * PIX + GAP + 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_pixel_streamer_if bus ();

  oled_pixel_streamer #(
    .WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .GAP_CYCLES(GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stub renderer: constant colour, or black rectangle x 8..20, y 9..11 on white.
  logic        mode = 1'b0;
  logic [15:0] cval = 16'hF800;
  always_comb begin
    if (mode)
      bus.oled_data = (bus.x >= 7'd8 && bus.x <= 7'd20 && bus.y >= 6'd9 && bus.y <= 6'd11)
                      ? 16'h0000 : 16'hFFFF;
    else
      bus.oled_data = cval;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: reconstructs the serial words and checks raster order.
  int bitcnt = 0, prev_sclk = 1, rise0 = 0, rise_gap = 0;
  int lsx = 0, lsy = 0, done_x = 0, done_y = 0, done_seq = 0;
  int fb_count = 0, frame_samples = 0, last_frame_samples = 0, total_samples = 0;
  int frame_wraps = 0, last_frame_wraps = 0, raster_err = 0, cs_glitch = 0;
  logic [15:0] word = '0, done_word = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bitcnt    = 0;
      prev_sclk = 1;
    end else begin
      if (bus.frame_begin) begin
        fb_count++;
        last_frame_samples = frame_samples;
        frame_samples      = 0;
        last_frame_wraps   = frame_wraps;
        frame_wraps        = 0;
      end
      if (bus.sample_pixel) begin
        if (bus.frame_begin) begin
          if (bus.x != 0 || bus.y != 0) raster_err++;
        end else begin
          int ex, ey;
          ex = (lsx == W - 1) ? 0 : lsx + 1;
          ey = (lsx == W - 1) ? lsy + 1 : lsy;
          if (int'(bus.x) != ex || int'(bus.y) != ey) raster_err++;
          if (lsx == W - 1 && bus.x == 0) frame_wraps++;
        end
        lsx = int'(bus.x);
        lsy = int'(bus.y);
        frame_samples++;
        total_samples++;
        bitcnt = 0;
      end
      if (bus.busy && bus.cs_n) cs_glitch++;
      if (bus.sclk && prev_sclk == 0) begin
        if (bitcnt == 0) rise0 = cyc;
        if (bitcnt == 1) rise_gap = cyc - rise0;
        word = {word[14:0], bus.sdin};
        bitcnt++;
        if (bitcnt == 16) begin
          done_x    = lsx;
          done_y    = lsy;
          done_word = word;
          done_seq++;
        end
      end
      prev_sclk = int'(bus.sclk);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fb(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.frame_begin) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_load(input int px, input int py, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.sample_pixel && int'(bus.x) == px && int'(bus.y) == py) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int px, input int py, input int bound,
                           output logic [15:0] w, output bit ok);
    int seen;
    seen = done_seq;
    ok   = 1'b0;
    w    = '0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_seq != seen) begin
        seen = done_seq;
        if (done_x == px && done_y == py) begin w = done_word; ok = 1'b1; break; end
      end
    end
  endtask

  task automatic wait_cs_high(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.cs_n) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    bit          mode;
    logic [15:0] cval;
    int          px;
    int          py;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit ok;
    logic [15:0] w;
    int t0, g, bad, fb_prev;

    vecs[0]  = '{1'b1, 16'h0000,  0,  0, 16'hFFFF};
    vecs[1]  = '{1'b0, 16'hA5C3,  1,  0, 16'hA5C3};
    vecs[2]  = '{1'b0, 16'h0001,  2,  0, 16'h0001};
    vecs[3]  = '{1'b0, 16'h8000, 23,  0, 16'h8000};
    vecs[4]  = '{1'b1, 16'h0000,  8,  8, 16'hFFFF};
    vecs[5]  = '{1'b1, 16'h0000,  7,  9, 16'hFFFF};
    vecs[6]  = '{1'b1, 16'h0000,  8,  9, 16'h0000};
    vecs[7]  = '{1'b1, 16'h0000, 20,  9, 16'h0000};
    vecs[8]  = '{1'b1, 16'h0000, 21,  9, 16'hFFFF};
    vecs[9]  = '{1'b0, 16'h5A5A, 14, 10, 16'h5A5A};
    vecs[10] = '{1'b1, 16'h0000, 20, 11, 16'h0000};
    vecs[11] = '{1'b1, 16'h0000, 23, 11, 16'hFFFF};

    // Reset held with enable high: nothing may move.
    bus.enable = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("reset_pins{cs_n,sclk,sdin,dc,busy,fb}",
          {26'd0, bus.cs_n, bus.sclk, bus.sdin, bus.dc, bus.busy, bus.frame_begin}, 32'b110000);
    check("reset_xy", {19'd0, bus.x, bus.y}, 32'd0);
    check("reset_no_activity", fb_count + total_samples, 0);
    $display("reset phase: cs_n=%0b sclk=%0b x=%0d y=%0d", bus.cs_n, bus.sclk, bus.x, bus.y);

    // First pixel, constant F800.
    rst_n = 1'b1;
    wait_fb(20, ok);
    check("first_frame_begin_seen", ok, 1);
    t0 = cyc;
    check("load_pins{sample,cs_n,dc,busy,sclk}",
          {27'd0, bus.sample_pixel, bus.cs_n, bus.dc, bus.busy, bus.sclk}, 32'b10111);
    check("load_xy", {19'd0, bus.x, bus.y}, 32'd0);
    step();
    check("frame_begin_one_cycle", bus.frame_begin, 0);
    check("shift_start{sclk,sdin}", {30'd0, bus.sclk, bus.sdin}, 32'b01);
    wait_done(0, 0, 200, w, ok);
    check("pix(0,0)_const_word", {15'd0, ok, w}, {16'd1, 16'hF800});
    check("sclk_period", rise_gap, 2 * CD);
    wait_load(1, 0, 100, ok);
    check("pixel_period", ok ? (cyc - t0) : -1, PIX);
    $display("first pixel: word=%h sclk_period=%0d next_load=%0d", w, rise_gap, cyc - t0);

    // Rest of frame 1 with the rectangle renderer; then the inter-frame gap.
    mode = 1'b1;
    wait_cs_high(FRAME, ok);
    check("frame1_end_seen", ok, 1);
    g = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.cs_n) break;
      g++;
      if (!bus.sclk || bus.dc || bus.sdin || bus.busy) bad++;
      step();
    end
    check("gap_length", g, GAP);
    check("gap_idle_pins", bad, 0);
    check("gap_then_frame_begin", bus.frame_begin, 1);
    check("gap_then_xy0", {19'd0, bus.x, bus.y}, 32'd0);
    check("frame1_samples", last_frame_samples, W * H);
    check("frame1_row_wraps", last_frame_wraps, H - 1);
    $display("frame1: gap=%0d samples=%0d wraps=%0d", g, last_frame_samples, last_frame_wraps);

    // Frame 2: table of per-pixel renderer settings and expected words.
    for (int i = 0; i < 12; i++) begin
      mode = vecs[i].mode;
      cval = vecs[i].cval;
      wait_done(vecs[i].px, vecs[i].py, FRAME, w, ok);
      check($sformatf("pix(%0d,%0d)", vecs[i].px, vecs[i].py), {15'd0, ok, w}, {16'd1, vecs[i].exp});
      $display("vector %0d: pix(%0d,%0d) word=%h expect=%h", i, vecs[i].px, vecs[i].py, w, vecs[i].exp);
    end

    // Frame 3: drop enable mid-frame; the frame still completes then goes idle.
    wait_load(20, 10, FRAME, ok);
    check("frame3_pix(20,10)_reached", ok, 1);
    bus.enable = 1'b0;
    fb_prev = fb_count;
    wait_cs_high(FRAME, ok);
    check("frame3_end_seen", ok, 1);
    check("frame3_last_pixel", lsx * 256 + lsy, (W - 1) * 256 + (H - 1));
    for (int i = 0; i < GAP + 40; i++) step();
    check("idle_pins{busy,cs_n,sclk,dc}", {28'd0, bus.busy, bus.cs_n, bus.sclk, bus.dc}, 32'b0110);
    check("idle_no_new_frame", fb_count, fb_prev);
    check("frame3_samples", frame_samples, W * H);
    check("idle_xy", {19'd0, bus.x, bus.y}, 32'd0);
    $display("enable drop: samples=%0d busy=%0b frames=%0d", frame_samples, bus.busy, fb_count);

    // Async reset during bit 7 of pixel (3,2).
    mode = 1'b0;
    cval = 16'hFFFF;
    bus.enable = 1'b1;
    wait_fb(100, ok);
    check("restart_from_idle", ok, 1);
    wait_load(3, 2, 60 * PIX, ok);
    check("pix(3,2)_reached", ok, 1);
    for (int i = 0; i < 200; i++) begin
      step();
      if (bitcnt == 8 && !bus.sclk) break;
    end
    check("pre_reset{busy,sdin,x}", {23'd0, bus.busy, bus.sdin, bus.x}, {23'd0, 1'b1, 1'b1, 7'd3});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_pins{cs_n,sclk,sdin,dc,busy}",
          {27'd0, bus.cs_n, bus.sclk, bus.sdin, bus.dc, bus.busy}, 32'b11000);
    check("async_reset_xy", {19'd0, bus.x, bus.y}, 32'd0);
    $display("async reset: cs_n=%0b sclk=%0b sdin=%0b x=%0d y=%0d", bus.cs_n, bus.sclk, bus.sdin, bus.x, bus.y);
    for (int i = 0; i < 3; i++) step();
    fb_prev = fb_count;
    rst_n = 1'b1;
    wait_fb(10, ok);
    check("post_reset_frame_begin", {31'd0, ok}, 1);
    check("post_reset_xy", {19'd0, bus.x, bus.y}, 32'd0);
    check("post_reset_fb_count", fb_count, fb_prev + 1);
    wait_done(0, 0, 200, w, ok);
    check("post_reset_pix(0,0)", {15'd0, ok, w}, {16'd1, 16'hFFFF});

    check("raster_order_errors", raster_err, 0);
    check("cs_n_high_while_busy", cs_glitch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
